// File: rtl/mode_abcd_sls_detector.sv
// SSR Mode A/B/C/D interrogation detector with P2 side-lobe suppression.
// Follows P1 with a timed window for an optional P2 and one P3 window per
// mode. Emits one message per decoded interrogation, an SLS strobe, or a
// reject strobe for any sequence that does not decode.
module mode_abcd_sls_detector #(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 12,
    parameter int TOL       = 3,
    parameter int P2_LO     = 118,
    parameter int P2_HI     = 128,
    parameter int PEAK_LEN  = 20,
    parameter int P3A_C     = 492,
    parameter int P3B_C     = 1044,
    parameter int P3C_C     = 1290,
    parameter int P3D_C     = 1536,
    parameter int SLS_SHIFT = 2,
    parameter int SUPP_LEN  = 2150
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rise_in,
    input  logic                 pulse_validated,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [3:0]           mode_en,
    output logic                 msg_valid,
    output logic [2*WIDTH+7:0]   msg_data,
    output logic                 sls_pulse,
    output logic                 reject_pulse,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SUPP = 2'd2;

    // A and C keep the legacy codes; B and D take the next free bits.
    localparam logic [7:0] CODE_A = 8'h01;
    localparam logic [7:0] CODE_C = 8'h02;
    localparam logic [7:0] CODE_B = 8'h04;
    localparam logic [7:0] CODE_D = 8'h08;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p2cnt;
    logic [WIDTH-1:0] p1_peak;
    logic [WIDTH-1:0] p2_peak;
    logic             p2_seen;

    logic             edge_det;
    logic             p2_win;
    logic             timeout;
    logic             sls_hit;
    logic [3:0]       win;
    logic             hit_any;
    logic [7:0]       sel_code;
    logic [WIDTH-1:0] sls_thr;

    function automatic logic in_win(input logic [CNT_W-1:0] c, input int centre);
        int v;
        v = int'(c);
        return (v >= centre - TOL) && (v <= centre + TOL);
    endfunction

    assign edge_det = rise_in & pulse_validated;
    assign p2_win   = (int'(cnt) >= P2_LO) && (int'(cnt) <= P2_HI);
    assign timeout  = int'(cnt) > (P3D_C + TOL);
    assign sls_thr  = p1_peak - (p1_peak >> SLS_SHIFT);
    assign sls_hit  = p2_seen && (int'(p2cnt) == PEAK_LEN) && (p2_peak >= sls_thr);
    assign busy     = (state != S_IDLE);

    assign win[0] = in_win(cnt, P3A_C);
    assign win[1] = in_win(cnt, P3B_C);
    assign win[2] = in_win(cnt, P3C_C);
    assign win[3] = in_win(cnt, P3D_C);

    // Pick the enabled P3 window the counter sits in; A first if windows overlap.
    always_comb begin
        hit_any  = 1'b1;
        sel_code = 8'h00;
        if (win[0] && mode_en[0])      sel_code = CODE_A;
        else if (win[1] && mode_en[1]) sel_code = CODE_B;
        else if (win[2] && mode_en[2]) sel_code = CODE_C;
        else if (win[3] && mode_en[3]) sel_code = CODE_D;
        else                           hit_any = 1'b0;
    end

    // Sequence FSM: peak tracking, P2/P3 window decode, SLS and suppression hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            p2cnt        <= '0;
            p1_peak      <= '0;
            p2_peak      <= '0;
            p2_seen      <= 1'b0;
            msg_valid    <= 1'b0;
            msg_data     <= '0;
            sls_pulse    <= 1'b0;
            reject_pulse <= 1'b0;
        end else begin
            msg_valid    <= 1'b0;
            sls_pulse    <= 1'b0;
            reject_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (edge_det) begin
                        cnt     <= '0;
                        p2cnt   <= '0;
                        p1_peak <= data_in;
                        p2_peak <= '0;
                        p2_seen <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (int'(cnt) < PEAK_LEN && data_in > p1_peak)
                        p1_peak <= data_in;
                    // p2cnt stops one past PEAK_LEN so the SLS compare fires once.
                    if (p2_seen && int'(p2cnt) <= PEAK_LEN)
                        p2cnt <= p2cnt + 1'b1;
                    if (p2_seen && int'(p2cnt) < PEAK_LEN && data_in > p2_peak)
                        p2_peak <= data_in;
                    if (sls_hit) begin
                        // SLS outranks any edge arriving in the same cycle.
                        sls_pulse <= 1'b1;
                        cnt       <= '0;
                        state     <= S_SUPP;
                    end else if (edge_det) begin
                        if (p2_win && !p2_seen) begin
                            p2_seen <= 1'b1;
                            p2_peak <= data_in;
                            p2cnt   <= '0;
                        end else if (hit_any) begin
                            msg_valid <= 1'b1;
                            msg_data  <= {p1_peak, p2_peak, sel_code};
                            state     <= S_IDLE;
                        end else begin
                            reject_pulse <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end else if (timeout) begin
                        reject_pulse <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_SUPP: begin
                    cnt <= cnt + 1'b1;
                    if (int'(cnt) == SUPP_LEN - 1) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_abcd_sls_detector.sv
// Directed bench for mode_abcd_sls_detector. Positions are given in WAIT
// counter units: the first WAIT cycle after the P1 edge has cnt=0.
module tb_mode_abcd_sls_detector;

    localparam logic [15:0] LO = 16'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rise_in;
    logic        pulse_validated;
    logic [15:0] data_in;
    logic [3:0]  mode_en;
    logic        msg_valid;
    logic [39:0] msg_data;
    logic        sls_pulse;
    logic        reject_pulse;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cnt_m = 0;
    int n_msg = 0;
    int n_sls = 0;
    int n_rej = 0;
    int nb;

    mode_abcd_sls_detector dut (
        .clk             (clk),
        .rst             (rst),
        .rise_in         (rise_in),
        .pulse_validated (pulse_validated),
        .data_in         (data_in),
        .mode_en         (mode_en),
        .msg_valid       (msg_valid),
        .msg_data        (msg_data),
        .sls_pulse       (sls_pulse),
        .reject_pulse    (reject_pulse),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given edge/sample; outputs sampled 1ns after the edge.
    task automatic clk1(input logic e, input logic [15:0] d);
        rise_in = e;
        data_in = d;
        @(posedge clk);
        #1;
        rise_in = 1'b0;
        data_in = LO;
        if (msg_valid)    n_msg++;
        if (sls_pulse)    n_sls++;
        if (reject_pulse) n_rej++;
    endtask

    task automatic p1(input logic [15:0] amp);
        n_msg = 0;
        n_sls = 0;
        n_rej = 0;
        clk1(1'b1, amp);
        cnt_m = 0;
    endtask

    task automatic idle_to(input int k);
        while (cnt_m < k) begin
            clk1(1'b0, LO);
            cnt_m++;
        end
    endtask

    task automatic edge_at(input int k, input logic [15:0] amp);
        idle_to(k);
        clk1(1'b1, amp);
        cnt_m++;
    endtask

    task automatic data_at(input int k, input logic [15:0] amp);
        idle_to(k);
        clk1(1'b0, amp);
        cnt_m++;
    endtask

    task automatic expect_msg(input string tag, input logic [39:0] exp);
        chk({tag, "_valid"}, msg_valid, 1);
        chk({tag, "_data"}, msg_data, exp);
        chk({tag, "_rej"}, n_rej, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        rise_in = 1'b0;
        pulse_validated = 1'b1;
        data_in = LO;
        mode_en = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", msg_valid, 0);
        chk("rst_data", msg_data, 0);
        chk("rst_sls", sls_pulse, 0);
        chk("rst_rej", reject_pulse, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        clk1(1'b0, LO);

        // Masked edge must not start a sequence.
        pulse_validated = 1'b0;
        clk1(1'b1, 16'd900);
        chk("pv_mask_busy", busy, 0);
        pulse_validated = 1'b1;

        // Mode A with P2, peaks tracked above the edge samples.
        p1(16'd900);
        chk("a_busy", busy, 1);
        data_at(3, 16'd1000);
        edge_at(120, 16'd300);
        data_at(123, 16'd500);
        edge_at(492, LO);
        expect_msg("mode_a", {16'd1000, 16'd500, 8'h01});
        chk("mode_a_sls", n_sls, 0);
        clk1(1'b0, LO);
        chk("mode_a_strobe", msg_valid, 0);

        // Modes B, C, D without P2.
        p1(16'd800);
        edge_at(1044, LO);
        expect_msg("mode_b", {16'd800, 16'd0, 8'h04});
        p1(16'd800);
        edge_at(1290, LO);
        expect_msg("mode_c", {16'd800, 16'd0, 8'h02});
        p1(16'd800);
        edge_at(1536, LO);
        expect_msg("mode_d", {16'd800, 16'd0, 8'h08});

        // SLS: 760 >= 1000-250; compare at p2cnt==20 (cnt=141).
        p1(16'd1000);
        edge_at(120, 16'd760);
        idle_to(141);
        chk("sls_early", n_sls, 0);
        clk1(1'b0, LO);
        cnt_m++;
        chk("sls_pulse", sls_pulse, 1);
        nb = 0;
        while (busy && nb < 3000) begin
            nb++;
            clk1(nb == 351, 16'd900);
        end
        chk("supp_len", nb, 2150);
        chk("supp_no_msg", n_msg, 0);
        chk("supp_no_rej", n_rej, 0);
        p1(16'd600);
        edge_at(492, LO);
        expect_msg("post_supp", {16'd600, 16'd0, 8'h01});

        // 740 < 750: no SLS, decode carries P2 peak.
        p1(16'd1000);
        edge_at(120, 16'd740);
        edge_at(492, LO);
        expect_msg("no_sls", {16'd1000, 16'd740, 8'h01});
        chk("no_sls_pulse", n_sls, 0);

        // Window boundaries with mode A.
        p1(16'd400);
        edge_at(489, LO);
        expect_msg("a_lo_edge", {16'd400, 16'd0, 8'h01});
        p1(16'd400);
        edge_at(488, LO);
        chk("a_lo_out", reject_pulse, 1);
        chk("a_lo_out_msg", n_msg, 0);

        // B disabled.
        mode_en = 4'b1101;
        p1(16'd800);
        edge_at(1044, LO);
        chk("b_dis_rej", reject_pulse, 1);
        chk("b_dis_msg", n_msg, 0);
        chk("b_dis_busy", busy, 0);
        p1(16'd800);
        edge_at(495, LO);
        expect_msg("a_hi_edge", {16'd800, 16'd0, 8'h01});
        p1(16'd800);
        edge_at(496, LO);
        chk("a_hi_out", reject_pulse, 1);
        chk("a_hi_out_msg", n_msg, 0);
        mode_en = 4'hF;

        // Reset mid-sequence: async clear, msg_data drops the last message.
        p1(16'd700);
        idle_to(300);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", msg_data, 0);
        chk("mid_rst_valid", msg_valid, 0);
        chk("mid_rst_rej", reject_pulse, 0);
        #2;
        rst = 1'b0;
        p1(16'd700);
        edge_at(492, LO);
        expect_msg("after_rst", {16'd700, 16'd0, 8'h01});

        // Timeout with every mode disabled.
        mode_en = 4'h0;
        p1(16'd500);
        idle_to(1540);
        chk("tmo_early", n_rej, 0);
        clk1(1'b0, LO);
        chk("tmo_rej", reject_pulse, 1);
        chk("tmo_busy", busy, 0);
        mode_en = 4'hF;

        // Stray edge and second P2 edge.
        p1(16'd500);
        edge_at(60, LO);
        chk("stray_rej", reject_pulse, 1);
        p1(16'd500);
        edge_at(120, 16'd100);
        edge_at(125, 16'd100);
        chk("p2_twice_rej", reject_pulse, 1);
        chk("p2_twice_msg", n_msg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_abcd_sls_detector.md
Name: mode_abcd_sls_detector

Overview:
- Parametrised successor to the Mode A/C interrogation detector.
- Decodes SSR pulse trains of the form P1, optional P2, then P3 for Modes A, B, C and D, each mode selected by a runtime enable mask.
- Performs side-lobe suppression (SLS) by comparing the P2 amplitude against the P1 amplitude, then holds off for a suppression interval.
- Sits after the pulse-edge and width-qualification stages. Feeds the reply scheduler with one message per decoded interrogation.

Parameters:
WIDTH, 16, magnitude sample width
CNT_W, 12, timing counter width (must hold SUPP_LEN and P3D_C+TOL)
TOL, 3, +/- window tolerance in clocks for all P3 windows
P2_LO, 118, P2 window start (clocks after P1 edge)
P2_HI, 128, P2 window end
PEAK_LEN, 20, peak-tracking length in clocks for P1 and for P2
P3A_C, 492, Mode A P3 centre
P3B_C, 1044, Mode B P3 centre
P3C_C, 1290, Mode C P3 centre
P3D_C, 1536, Mode D P3 centre
SLS_SHIFT, 2, SLS threshold = p1_peak - (p1_peak >> SLS_SHIFT)
SUPP_LEN, 2150, suppression hold in clocks

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rise_in  in  1  1-cycle rising-edge strobe
pulse_validated  in  1  qualifies rise_in; edge = rise_in & pulse_validated
data_in  in  WIDTH  magnitude sample
mode_en  in  4  enable mask {D,C,B,A}; sampled every cycle
msg_valid  out  1  1-cycle strobe, msg_data valid
msg_data  out  2*WIDTH+8  {p1_peak, p2_peak, mode_code}
sls_pulse  out  1  1-cycle strobe on SLS decision
reject_pulse  out  1  1-cycle strobe on aborted sequence
busy  out  1  high whenever state != IDLE

Behaviour:
Interface:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset clears all outputs to 0, state to IDLE, and all counters and peaks to 0.
- pulse_validated low does not reset the block; it only masks edges.

Mode codes:
- A=8'h01, C=8'h02, B=8'h04, D=8'h08.
- A and C keep the legacy encoding.

State machine (IDLE, WAIT, SUPPRESS). Strobe outputs default to 0 each cycle.

IDLE:
- On edge: cnt<=0, p1_peak<=data_in, p2_peak<=0, p2_seen<=0, go to WAIT.

WAIT (cnt increments every cycle):
- P1 peak: while cnt<PEAK_LEN, p1_peak<=max(p1_peak,data_in).
- P2 capture: an edge with P2_LO<=cnt<=P2_HI and !p2_seen sets p2_seen, p2_peak<=data_in and p2cnt<=0.
- P2 peak: while p2_seen and p2cnt<PEAK_LEN, p2_peak<=max(p2_peak,data_in) and p2cnt increments.
- SLS check: at the cycle p2cnt==PEAK_LEN, if p2_peak >= p1_peak-(p1_peak>>SLS_SHIFT) (unsigned, full WIDTH):
  - sls_pulse=1, cnt<=0, go to SUPPRESS.
  - If an edge arrives in that same cycle, SLS wins and the edge is ignored.
- P3 windows: an edge with |cnt-P3x_C|<=TOL and mode_en[x]=1 triggers a report on the next cycle:
  - msg_valid=1, msg_data={p1_peak,p2_peak,code}, go to IDLE.
  - p2_peak is 0 when no P2 was seen.
- Rejects (reject_pulse=1, go to IDLE):
  - an edge anywhere else, including a second P2 edge, a P2 edge before P2_LO, or an edge in a disabled mode window;
  - cnt > P3D_C+TOL (timeout), regardless of mode_en.
- Latency: msg_valid is asserted exactly 1 clock after the qualifying P3 edge.

SUPPRESS:
- All edges are ignored.
- After SUPP_LEN clocks (cnt==SUPP_LEN-1), go to IDLE.
- busy stays high throughout.

Boundaries:
- An edge exactly at P3x_C-TOL or P3x_C+TOL is accepted.
- An edge at P3x_C±(TOL+1) is rejected.
- Windows are assumed non-overlapping. If parameters make them overlap, the lowest mode index (A) wins.
- An edge in the same cycle as the timeout is evaluated as a window hit first.
- Reset asserted mid-sequence aborts immediately with no msg_valid or reject_pulse.
- cnt never wraps: the timeout fires before CNT_W overflows.

Test Plan:
- mode_en=4'hF; P1 peak 1000 at t=0; P2 peak 500 at cnt=123; P3 at cnt=492 -> msg_valid at cnt=493, msg_data={1000,500,8'h01}, no sls_pulse.
- P1 peak 800, no P2, P3 at cnt=1044 -> msg_data={800,0,8'h04}. Repeat at 1290 -> code 8'h02; at 1536 -> code 8'h08.
- P1 peak 1000, P2 peak 760 at cnt=120 -> sls_pulse at 20 clocks after the P2 edge; a P3 at 492 is ignored; busy high for 2150 clocks; a fresh P1 after that decodes normally. Repeat with P2 peak 740 -> no SLS.
- mode_en=4'b1101 (B disabled), P3 at cnt=1044 -> reject_pulse, no msg_valid. P3 at 495 -> accept; at 496 -> reject.
- P1 only, no further edges -> reject_pulse at cnt=1540. Extra edge at cnt=60 -> immediate reject_pulse.
- rst pulsed during WAIT at cnt=300 -> outputs 0 asynchronously, busy=0; the next P1 is accepted normally.
